// File: rtl/sprite_layer_engine.sv
// sprite_layer_engine: N-channel ROM-backed sprite compositor.
// Each pixel from the display timing generator passes through a fixed 3-stage pipeline:
//   stage 1: hit test against the frame-latched sprite positions, ROM address formation
//   stage 2: external ROMs return data (1-cycle registered read), hit flags realigned
//   stage 3: transparency keying, fixed priority (lowest index on top), collision accumulate
// Positions/enables/mirror bits are shadowed on frame_start so a sprite never tears mid-frame.
module sprite_layer_engine #(
    parameter int          NUM_SPR = 4,
    parameter int          SPR_W   = 32,
    parameter int          SPR_H   = 64,
    parameter int          AW      = 11,
    parameter logic [11:0] TRANSP  = 12'h000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    video_on,
    input  logic [9:0]              pix_row,
    input  logic [9:0]              pix_col,
    input  logic [NUM_SPR*10-1:0]   spr_x_in,
    input  logic [NUM_SPR*10-1:0]   spr_y_in,
    input  logic [NUM_SPR-1:0]      spr_en_in,
    input  logic [NUM_SPR-1:0]      spr_mirror_in,
    output logic [NUM_SPR*AW-1:0]   rom_addr,
    input  logic [NUM_SPR*12-1:0]   rom_data,
    output logic [11:0]             pix_out,
    output logic                    pix_valid,
    output logic [2:0]              hit_id,
    output logic [NUM_SPR-1:0]      collision
);

    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);

    // Frame-latched sprite attributes
    logic [NUM_SPR-1:0][9:0]    sx_q, sx_d;
    logic [NUM_SPR-1:0][9:0]    sy_q, sy_d;
    logic [NUM_SPR-1:0]         sen_q, sen_d;
    logic [NUM_SPR-1:0]         smir_q, smir_d;

    // Stage 1: hit flags and sprite-local coordinates
    logic [NUM_SPR-1:0]         in1_q, in1_d;
    logic [NUM_SPR-1:0][XB-1:0] dx_q, dx_d;
    logic [NUM_SPR-1:0][YB-1:0] dy_q, dy_d;
    logic [NUM_SPR-1:0]         mir1_q, mir1_d;

    // Stage 2: hit flags aligned with ROM data
    logic [NUM_SPR-1:0]         in2_q, in2_d;

    // Stage 3: composited output and collision tracking
    logic [11:0]                pix_q, pix_d;
    logic                       valid_q, valid_d;
    logic [2:0]                 hit_q, hit_d;
    logic [NUM_SPR-1:0]         acc_q, acc_d;
    logic [NUM_SPR-1:0]         coll_q, coll_d;

    // Stage-0 scratch
    logic [10:0]                col11, row11, x11, y11;
    logic [XB-1:0]              dxm;
    logic [NUM_SPR-1:0]         opaque;
    logic [NUM_SPR-1:0]         overlap;

    // Shadow attributes: only frame_start lets new positions in
    always_comb begin
        sx_d   = sx_q;
        sy_d   = sy_q;
        sen_d  = sen_q;
        smir_d = smir_q;
        if (frame_start) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                sx_d[i] = spr_x_in[i*10 +: 10];
                sy_d[i] = spr_y_in[i*10 +: 10];
            end
            sen_d  = spr_en_in;
            smir_d = spr_mirror_in;
        end
    end

    // Stage 0->1: 11-bit bounding-box test so a sprite near column/row 1023 clips instead of wrapping.
    // Local coordinates (and the mirror bit) only advance on a hit, which keeps rom_addr parked
    // on its last in-range value while the beam is outside the sprite.
    always_comb begin
        col11  = {1'b0, pix_col};
        row11  = {1'b0, pix_row};
        x11    = '0;
        y11    = '0;
        in1_d  = '0;
        dx_d   = dx_q;
        dy_d   = dy_q;
        mir1_d = mir1_q;
        for (int i = 0; i < NUM_SPR; i++) begin
            x11 = {1'b0, sx_q[i]};
            y11 = {1'b0, sy_q[i]};
            in1_d[i] = sen_q[i] & video_on
                     & (col11 >= x11) & (col11 < x11 + 11'(SPR_W))
                     & (row11 >= y11) & (row11 < y11 + 11'(SPR_H));
            if (in1_d[i]) begin
                dx_d[i]   = pix_col[XB-1:0] - sx_q[i][XB-1:0];
                dy_d[i]   = pix_row[YB-1:0] - sy_q[i][YB-1:0];
                mir1_d[i] = smir_q[i];
            end
        end
    end

    // ROM address per sprite; SPR_W is a power of two so SPR_W-1-dx is just ~dx
    always_comb begin
        rom_addr = '0;
        dxm      = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            dxm = mir1_q[i] ? ~dx_q[i] : dx_q[i];
            rom_addr[i*AW +: AW] = {dy_q[i], dxm};
        end
    end

    // Stage 1->2: delay hit flags to line up with the registered ROM read
    always_comb begin
        in2_d = in1_q;
    end

    // Stage 2->3: colour keying, lowest-index-wins priority, per-frame collision accumulation
    always_comb begin
        opaque  = '0;
        overlap = '0;
        pix_d   = 12'h000;
        valid_d = 1'b0;
        hit_d   = 3'd0;
        for (int i = 0; i < NUM_SPR; i++) begin
            opaque[i] = in2_q[i] & (rom_data[i*12 +: 12] != TRANSP);
        end
        // Walk from highest to lowest so the lowest opaque index is the final winner
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pix_d   = rom_data[i*12 +: 12];
                valid_d = 1'b1;
                hit_d   = 3'(i);
            end
        end
        for (int i = 1; i < NUM_SPR; i++) begin
            overlap[i] = opaque[0] & opaque[i];
        end
        // Hits coinciding with frame_start belong to the frame that is ending
        acc_d  = acc_q | overlap;
        coll_d = coll_q;
        if (frame_start) begin
            coll_d = acc_q | overlap;
            acc_d  = '0;
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            sx_q    <= '0;
            sy_q    <= '0;
            sen_q   <= '0;
            smir_q  <= '0;
            in1_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            mir1_q  <= '0;
            in2_q   <= '0;
            pix_q   <= 12'h000;
            valid_q <= 1'b0;
            hit_q   <= 3'd0;
            acc_q   <= '0;
            coll_q  <= '0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sen_q   <= sen_d;
            smir_q  <= smir_d;
            in1_q   <= in1_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            mir1_q  <= mir1_d;
            in2_q   <= in2_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            acc_q   <= acc_d;
            coll_q  <= coll_d;
        end
    end

    assign pix_out   = pix_q;
    assign pix_valid = valid_q;
    assign hit_id    = hit_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_sprite_layer_engine.sv
// tb_sprite_layer_engine: directed checks of the sprite compositor with a behavioural ROM per sprite.
// ROM contents: ROM s at address a holds {4'(s+1), a[7:0]}, e.g. ROM0[31]=12'h11F, ROM2[25]=12'h319.
module tb_sprite_layer_engine;

    localparam int NUM = 4;
    localparam int AW  = 11;

    logic               clk;
    logic               reset;
    logic               frame_start;
    logic               video_on;
    logic [9:0]         pix_row;
    logic [9:0]         pix_col;
    logic [NUM*10-1:0]  spr_x_in;
    logic [NUM*10-1:0]  spr_y_in;
    logic [NUM-1:0]     spr_en_in;
    logic [NUM-1:0]     spr_mirror_in;
    logic [NUM*AW-1:0]  rom_addr;
    logic [NUM*12-1:0]  rom_data;
    logic [11:0]        pix_out;
    logic               pix_valid;
    logic [2:0]         hit_id;
    logic [NUM-1:0]     collision;

    logic [11:0]        rom [NUM][0:2047];
    logic [AW-1:0]      addr0_seen;
    int                 checks;
    int                 errors;

    sprite_layer_engine #(.NUM_SPR(NUM), .SPR_W(32), .SPR_H(64), .AW(AW), .TRANSP(12'h000)) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .video_on      (video_on),
        .pix_row       (pix_row),
        .pix_col       (pix_col),
        .spr_x_in      (spr_x_in),
        .spr_y_in      (spr_y_in),
        .spr_en_in     (spr_en_in),
        .spr_mirror_in (spr_mirror_in),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .pix_out       (pix_out),
        .pix_valid     (pix_valid),
        .hit_id        (hit_id),
        .collision     (collision)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ROMs with one-cycle registered read
    always @(posedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            rom_data[i*12 +: 12] <= rom[i][rom_addr[i*AW +: AW]];
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y,
                           input logic en, input logic mir);
        spr_x_in[i*10 +: 10] = x;
        spr_y_in[i*10 +: 10] = y;
        spr_en_in[i]         = en;
        spr_mirror_in[i]     = mir;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM; i++) set_spr(i, 10'd0, 10'd0, 1'b0, 1'b0);
    endtask

    // Called at a negedge, returns at a negedge
    task automatic do_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // One visible pixel surrounded by blanking; checks output lands exactly 3 edges later
    task automatic probe(input logic [9:0] r, input logic [9:0] c, input logic ev,
                         input logic [11:0] ep, input logic [2:0] eid, input string tag);
        pix_row  = r;
        pix_col  = c;
        video_on = 1'b1;
        @(negedge clk);
        video_on   = 1'b0;
        addr0_seen = rom_addr[AW-1:0];
        @(negedge clk);
        if (ev) check({tag, "_early"}, 32'(pix_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(pix_valid), 32'(ev));
        check({tag, "_pix"}, 32'(pix_out), 32'(ep));
        check({tag, "_id"}, 32'(hit_id), 32'(eid));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int s = 0; s < NUM; s++) begin
            for (int a = 0; a < 2048; a++) begin
                rom[s][a] = {4'(s + 1), 8'(a)};
            end
        end
        reset = 1'b1;
        frame_start = 1'b0;
        video_on = 1'b0;
        pix_row = '0;
        pix_col = '0;
        clear_all();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_pix", 32'(pix_out), 32'd0);
        check("rst_id", 32'(hit_id), 32'd0);
        check("rst_coll", 32'(collision), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);

        // Sprite 0 at x=100, y=50: corners and just-outside edges
        clear_all();
        set_spr(0, 10'd100, 10'd50, 1'b1, 1'b0);
        do_frame();
        probe(10'd50, 10'd100, 1'b1, 12'h100, 3'd0, "t2_tl");
        check("t2_addr_tl", 32'(addr0_seen), 32'd0);
        probe(10'd50, 10'd131, 1'b1, 12'h11F, 3'd0, "t2_tr");
        probe(10'd50, 10'd132, 1'b0, 12'h000, 3'd0, "t2_right_out");
        probe(10'd114, 10'd100, 1'b0, 12'h000, 3'd0, "t2_below_out");
        probe(10'd113, 10'd100, 1'b1, 12'h1E0, 3'd0, "t2_bl");   // addr 63*32=2016
        probe(10'd49, 10'd100, 1'b0, 12'h000, 3'd0, "t2_above_out");
        probe(10'd50, 10'd99, 1'b0, 12'h000, 3'd0, "t2_left_out");

        // Mirror: left edge reads column 31
        set_spr(0, 10'd100, 10'd50, 1'b1, 1'b1);
        do_frame();
        probe(10'd50, 10'd100, 1'b1, 12'h11F, 3'd0, "t3_mir_l");
        check("t3_addr_l", 32'(addr0_seen), 32'd31);
        probe(10'd50, 10'd131, 1'b1, 12'h100, 3'd0, "t3_mir_r");
        check("t3_addr_r", 32'(addr0_seen), 32'd0);

        // Priority with transparency: sprite 0 transparent at its origin
        clear_all();
        set_spr(0, 10'd100, 10'd50, 1'b1, 1'b0);
        set_spr(1, 10'd100, 10'd50, 1'b1, 1'b0);
        do_frame();
        rom[0][0] = 12'h000;
        probe(10'd50, 10'd100, 1'b1, 12'h200, 3'd1, "t4_transp");
        probe(10'd50, 10'd101, 1'b1, 12'h101, 3'd0, "t4_prio");
        rom[0][0] = 12'h100;

        // Position changes ignored until frame_start; sprite clips at column 1023
        clear_all();
        set_spr(0, 10'd100, 10'd50, 1'b1, 1'b0);
        do_frame();
        check("t4_coll", 32'(collision), 32'h2);   // sprite 0/1 overlap at (50,101)
        set_spr(0, 10'd200, 10'd50, 1'b1, 1'b0);
        probe(10'd50, 10'd100, 1'b1, 12'h100, 3'd0, "t6_nolatch");
        probe(10'd50, 10'd200, 1'b0, 12'h000, 3'd0, "t6_newpos");
        set_spr(0, 10'd1010, 10'd50, 1'b1, 1'b0);
        do_frame();
        probe(10'd50, 10'd1010, 1'b1, 12'h100, 3'd0, "t6_edge_l");
        probe(10'd50, 10'd1023, 1'b1, 12'h10D, 3'd0, "t6_edge_r");
        probe(10'd50, 10'd0, 1'b0, 12'h000, 3'd0, "t6_nowrap");
        probe(10'd50, 10'd1009, 1'b0, 12'h000, 3'd0, "t6_before");

        // Collision: sprite 0 over sprite 2; disabled sprite 1 sits on top of both
        clear_all();
        set_spr(0, 10'd100, 10'd50, 1'b1, 1'b0);
        set_spr(1, 10'd100, 10'd50, 1'b0, 1'b0);
        set_spr(2, 10'd110, 10'd50, 1'b1, 1'b0);
        do_frame();
        probe(10'd50, 10'd115, 1'b1, 12'h10F, 3'd0, "t5_overlap");
        check("t5_coll_hold", 32'(collision), 32'h0);
        do_frame();
        check("t5_coll_k1", 32'(collision), 32'h4);
        probe(10'd50, 10'd135, 1'b1, 12'h319, 3'd2, "t5_spr2_only");
        check("t5_coll_kept", 32'(collision), 32'h4);
        do_frame();
        check("t5_coll_k2", 32'(collision), 32'h0);

        // Reset mid-frame with sprite 0 on screen and a collision latched
        probe(10'd50, 10'd115, 1'b1, 12'h10F, 3'd0, "t1_overlap");
        do_frame();
        check("t1_coll_pre", 32'(collision), 32'h4);
        pix_row  = 10'd50;
        pix_col  = 10'd100;
        video_on = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_valid_pre", 32'(pix_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t1_valid", 32'(pix_valid), 32'd0);
        check("t1_pix", 32'(pix_out), 32'd0);
        check("t1_coll", 32'(collision), 32'd0);
        reset    = 1'b0;
        video_on = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_post", 32'(pix_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
